// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ALU_REGFILE_defs
//   Shared widths and ALU operation encoding for the ALU/register-file
//   datapath.
// ---------------------------------------------------------------------------
package ALU_REGFILE_defs;
  localparam int REGFILE_ADDR_WIDTH = 4;   // 16 registers
  localparam int REGFILE_WIDTH      = 16;  // register data width
  localparam int ALU_OUTPUT_WIDTH   = 17;  // one extra bit carries carry/borrow

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,  // a + b + cin
    ALU_SUB    = 3'd1,  // a - b - cin
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5
  } aluop_t;
endpackage

// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Multi-cycle sequencer for the ALU/register-file datapath. It accepts one
//   register-to-register instruction per valid/ready handshake and then runs
//   IDLE -> EXEC -> WB -> IDLE:
//     EXEC : drives read addresses, opcode and carry-in; ALU_Out is captured
//            at the end of the cycle.
//     WB   : pulses Result_Valid, optionally writes the result back, then
//            updates the sticky carry flag and the completed-instruction count.
//
// Ports
//   Clock, Reset_n                  clock, asynchronous active-low reset
//   Instr_Valid / Instr_Ready       instruction handshake
//   Instr_Opcode, Instr_Rs1/Rs2/Rd  instruction fields (sampled on accept only)
//   Instr_Carry, Instr_Use_Flag     explicit carry-in, or use Carry_Flag instead
//   Instr_Wb                        1: write result to Rd, 0: report only
//   Read_Addr_1/2, Opcode, Carry_In datapath read/ALU controls
//   Write_Addr/enable/data          datapath register-file write port
//   ALU_Out                         combinational ALU result from datapath
//   Result, Result_Valid            captured result and its one-cycle strobe
//   Carry_Flag                      sticky carry (bit REGFILE_WIDTH of result)
//   Instr_Count                     completed instructions, wraps at 16 bits
//
// Build option
//   ALU_SEQ_HOST_LOAD_EN : adds Load_Valid/Load_Ready/Load_Addr/Load_Data, a
//   host port that writes the register file directly while the sequencer is
//   idle. A load has priority over a simultaneous instruction.
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import ALU_REGFILE_defs::aluop_t;
#(
  parameter int REGFILE_ADDR_WIDTH = ALU_REGFILE_defs::REGFILE_ADDR_WIDTH,
  parameter int REGFILE_WIDTH      = ALU_REGFILE_defs::REGFILE_WIDTH,
  parameter int ALU_OUTPUT_WIDTH   = ALU_REGFILE_defs::ALU_OUTPUT_WIDTH
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  // instruction handshake
  input  logic                          Instr_Valid,
  output logic                          Instr_Ready,
  input  aluop_t                        Instr_Opcode,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Rs1,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Rs2,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Rd,
  input  logic                          Instr_Carry,
  input  logic                          Instr_Use_Flag,
  input  logic                          Instr_Wb,
`ifdef ALU_SEQ_HOST_LOAD_EN
  // host register load
  input  logic                          Load_Valid,
  output logic                          Load_Ready,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Load_Addr,
  input  logic [REGFILE_WIDTH-1:0]      Load_Data,
`endif
  // datapath control
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
  output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
  output aluop_t                        Opcode,
  output logic                          Carry_In,
  output logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
  output logic                          Write_enable,
  output logic [REGFILE_WIDTH-1:0]      Write_data,
  input  logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out,
  // result reporting
  output logic [ALU_OUTPUT_WIDTH-1:0]   Result,
  output logic                          Result_Valid,
  output logic                          Carry_Flag,
  output logic [15:0]                   Instr_Count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t                        state_reg;
  logic                          instr_ready_reg;
  logic [REGFILE_ADDR_WIDTH-1:0] read_addr_1_reg;
  logic [REGFILE_ADDR_WIDTH-1:0] read_addr_2_reg;
  aluop_t                        opcode_reg;
  logic                          carry_in_reg;
  logic [REGFILE_ADDR_WIDTH-1:0] rd_reg;
  logic                          wb_reg;
  logic [REGFILE_ADDR_WIDTH-1:0] write_addr_reg;
  logic                          write_enable_reg;
  logic [REGFILE_WIDTH-1:0]      write_data_reg;
  logic [ALU_OUTPUT_WIDTH-1:0]   result_reg;
  logic                          result_valid_reg;
  logic                          carry_flag_reg;
  logic [15:0]                   instr_count_reg;

  logic                          instr_fire;
  logic                          result_carry;

  // The carry flag only exists when the ALU is wider than a register.
  if (ALU_OUTPUT_WIDTH > REGFILE_WIDTH) begin : g_carry_bit
    assign result_carry = result_reg[REGFILE_WIDTH];
  end else begin : g_no_carry_bit
    assign result_carry = 1'b0;
  end

`ifdef ALU_SEQ_HOST_LOAD_EN
  logic load_fire;

  // instr_ready_reg is high exactly when the FSM sits in IDLE out of reset,
  // which is also the only time a host load may use the write port.
  assign Load_Ready  = instr_ready_reg;
  assign load_fire   = Load_Valid & Load_Ready;
  // A pending load takes the cycle; the instruction waits one cycle.
  assign Instr_Ready = instr_ready_reg & ~Load_Valid;

  // Loads happen only in IDLE and WB writes only in WB, so the two never
  // compete for the write port.
  assign Write_enable = load_fire | write_enable_reg;
  assign Write_Addr   = load_fire ? Load_Addr : write_addr_reg;
  assign Write_data   = load_fire ? Load_Data : write_data_reg;
`else
  assign Instr_Ready  = instr_ready_reg;
  assign Write_enable = write_enable_reg;
  assign Write_Addr   = write_addr_reg;
  assign Write_data   = write_data_reg;
`endif

  assign instr_fire   = Instr_Valid & Instr_Ready;

  assign Read_Addr_1  = read_addr_1_reg;
  assign Read_Addr_2  = read_addr_2_reg;
  assign Opcode       = opcode_reg;
  assign Carry_In     = carry_in_reg;
  assign Result       = result_reg;
  assign Result_Valid = result_valid_reg;
  assign Carry_Flag   = carry_flag_reg;
  assign Instr_Count  = instr_count_reg;

  // Outputs are registered one state ahead: values needed in EXEC are loaded
  // on the accepting edge, values needed in WB on the EXEC->WB edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg        <= ST_IDLE;
      instr_ready_reg  <= 1'b0;
      read_addr_1_reg  <= '0;
      read_addr_2_reg  <= '0;
      opcode_reg       <= aluop_t'(3'd0);
      carry_in_reg     <= 1'b0;
      rd_reg           <= '0;
      wb_reg           <= 1'b0;
      write_addr_reg   <= '0;
      write_enable_reg <= 1'b0;
      write_data_reg   <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      carry_flag_reg   <= 1'b0;
      instr_count_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          instr_ready_reg <= 1'b1;
          if (instr_fire) begin
            read_addr_1_reg <= Instr_Rs1;
            read_addr_2_reg <= Instr_Rs2;
            opcode_reg      <= Instr_Opcode;
            // Carry_Flag is stable while idle, so the selection can be
            // resolved here rather than in EXEC.
            carry_in_reg    <= Instr_Use_Flag ? carry_flag_reg : Instr_Carry;
            rd_reg          <= Instr_Rd;
            wb_reg          <= Instr_Wb;
            instr_ready_reg <= 1'b0;
            state_reg       <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          result_reg       <= ALU_Out;
          write_data_reg   <= ALU_Out[REGFILE_WIDTH-1:0];
          write_addr_reg   <= rd_reg;
          write_enable_reg <= wb_reg;
          result_valid_reg <= 1'b1;
          state_reg        <= ST_WB;
        end

        ST_WB: begin
          write_enable_reg <= 1'b0;
          result_valid_reg <= 1'b0;
          carry_flag_reg   <= result_carry;
          instr_count_reg  <= instr_count_reg + 16'd1;
          instr_ready_reg  <= 1'b1;
          state_reg        <= ST_IDLE;
        end

        default: begin
          write_enable_reg <= 1'b0;
          result_valid_reg <= 1'b0;
          instr_ready_reg  <= 1'b0;
          state_reg        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: a behavioural register file + ALU stands in for
// the datapath, and a separate instruction-level model predicts every result,
// write, carry flag and instruction count.
module tb_alu_seq_ctrl;
  import ALU_REGFILE_defs::*;

  logic                          Clock;
  logic                          Reset_n;
  logic                          Instr_Valid;
  logic                          Instr_Ready;
  aluop_t                        Instr_Opcode;
  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Rs1, Instr_Rs2, Instr_Rd;
  logic                          Instr_Carry, Instr_Use_Flag, Instr_Wb;
  logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1, Read_Addr_2, Write_Addr;
  aluop_t                        Opcode;
  logic                          Carry_In, Write_enable;
  logic [REGFILE_WIDTH-1:0]      Write_data;
  logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out, Result;
  logic                          Result_Valid, Carry_Flag;
  logic [15:0]                   Instr_Count;
`ifdef ALU_SEQ_HOST_LOAD_EN
  logic                          Load_Valid, Load_Ready;
  logic [REGFILE_ADDR_WIDTH-1:0] Load_Addr;
  logic [REGFILE_WIDTH-1:0]      Load_Data;
`endif

  alu_seq_ctrl dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .Instr_Opcode(Instr_Opcode), .Instr_Rs1(Instr_Rs1), .Instr_Rs2(Instr_Rs2),
    .Instr_Rd(Instr_Rd), .Instr_Carry(Instr_Carry),
    .Instr_Use_Flag(Instr_Use_Flag), .Instr_Wb(Instr_Wb),
`ifdef ALU_SEQ_HOST_LOAD_EN
    .Load_Valid(Load_Valid), .Load_Ready(Load_Ready),
    .Load_Addr(Load_Addr), .Load_Data(Load_Data),
`endif
    .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2), .Opcode(Opcode),
    .Carry_In(Carry_In), .Write_Addr(Write_Addr), .Write_enable(Write_enable),
    .Write_data(Write_data), .ALU_Out(ALU_Out), .Result(Result),
    .Result_Valid(Result_Valid), .Carry_Flag(Carry_Flag),
    .Instr_Count(Instr_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ALU semantics of the datapath.
  function automatic logic [16:0] alu_fn(aluop_t op, logic [15:0] a,
                                         logic [15:0] b, logic c);
    case (op)
      ALU_ADD:    return {1'b0, a} + {1'b0, b} + {16'd0, c};
      ALU_SUB:    return {1'b0, a} - {1'b0, b} - {16'd0, c};
      ALU_AND:    return {1'b0, a & b};
      ALU_OR:     return {1'b0, a | b};
      ALU_XOR:    return {1'b0, a ^ b};
      ALU_PASS_A: return {1'b0, a};
      default:    return 17'd0;
    endcase
  endfunction

  // Datapath stand-in: combinational reads/ALU, register write on the edge.
  logic [15:0] dp_rf [16];
  assign ALU_Out = alu_fn(Opcode, dp_rf[Read_Addr_1], dp_rf[Read_Addr_2], Carry_In);
  always @(posedge Clock) if (Write_enable) dp_rf[Write_Addr] <= Write_data;

  // Instruction-level reference state.
  logic [15:0] m_rf [16];
  logic        m_carry;
  int          m_count;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one instruction starting in an IDLE cycle and follows it through
  // EXEC and WB. keep_valid leaves Instr_Valid high with junk fields so the
  // next call is accepted back-to-back.
  task automatic issue(input aluop_t op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic cin, input logic use_f,
                       input logic wb, input logic keep_valid);
    logic [16:0] exp_res;
    logic        exp_cin;
    logic [15:0] old_rd;
    exp_cin = use_f ? m_carry : cin;
    exp_res = alu_fn(op, m_rf[rs1], m_rf[rs2], exp_cin);
    old_rd  = m_rf[rd];
    Instr_Valid = 1'b1; Instr_Opcode = op; Instr_Rs1 = rs1; Instr_Rs2 = rs2;
    Instr_Rd = rd; Instr_Carry = cin; Instr_Use_Flag = use_f; Instr_Wb = wb;
    #1;
    check_val("ready_idle", Instr_Ready, 1);
    @(posedge Clock); #1;
    if (keep_valid) begin
      Instr_Opcode = aluop_t'($urandom_range(0, 5));
      Instr_Rs1 = 4'($urandom); Instr_Rs2 = 4'($urandom); Instr_Rd = 4'($urandom);
      Instr_Carry = 1'($urandom); Instr_Use_Flag = 1'($urandom); Instr_Wb = 1'($urandom);
    end else begin
      Instr_Valid = 1'b0;
    end
    // EXEC
    check_val("exec_ready", Instr_Ready, 0);
    check_val("exec_rvalid", Result_Valid, 0);
    check_val("exec_we", Write_enable, 0);
    check_val("exec_ra1", Read_Addr_1, rs1);
    check_val("exec_ra2", Read_Addr_2, rs2);
    check_val("exec_op", Opcode, op);
    check_val("exec_cin", Carry_In, exp_cin);
    @(posedge Clock); #1;
    // WB
    check_val("wb_rvalid", Result_Valid, 1);
    check_val("wb_result", Result, exp_res);
    check_val("wb_we", Write_enable, wb);
    check_val("wb_waddr", Write_Addr, rd);
    check_val("wb_wdata", Write_data, exp_res[15:0]);
    @(posedge Clock); #1;
    if (wb) m_rf[rd] = exp_res[15:0];
    m_carry = exp_res[16];
    m_count = (m_count + 1) % 65536;
    check_val("idle_rvalid", Result_Valid, 0);
    check_val("idle_we", Write_enable, 0);
    check_val("carry_flag", Carry_Flag, m_carry);
    check_val("instr_count", Instr_Count, m_count);
    check_val("rf_dest", dp_rf[rd], m_rf[rd]);
    $display("instr op=%0d rs1=%0d rs2=%0d rd=%0d cin=%0b use=%0b wb=%0b old=0x%04h result=0x%05h count=%0d",
             op, rs1, rs2, rd, exp_cin, use_f, wb, old_rd, exp_res, m_count);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; Instr_Valid = 1'b0; Instr_Opcode = ALU_ADD;
    Instr_Rs1 = '0; Instr_Rs2 = '0; Instr_Rd = '0;
    Instr_Carry = 1'b0; Instr_Use_Flag = 1'b0; Instr_Wb = 1'b0;
`ifdef ALU_SEQ_HOST_LOAD_EN
    Load_Valid = 1'b0; Load_Addr = '0; Load_Data = '0;
`endif
    for (int i = 0; i < 16; i++) m_rf[i] = 16'($urandom);
    m_rf[0] = 16'h0000; m_rf[1] = 16'h0005; m_rf[2] = 16'h0007;
    m_rf[4] = 16'hFFFF; m_rf[5] = 16'h0001; m_rf[6] = 16'h0000; m_rf[7] = 16'h0000;
    for (int i = 0; i < 16; i++) dp_rf[i] = m_rf[i];
    m_carry = 1'b0; m_count = 0;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check_val("rst_ready", Instr_Ready, 0);
    check_val("rst_we", Write_enable, 0);
    check_val("rst_rvalid", Result_Valid, 0);
    check_val("rst_carry", Carry_Flag, 0);
    check_val("rst_count", Instr_Count, 0);
    check_val("rst_result", Result, 0);
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    check_val("rel_ready", Instr_Ready, 1);
    check_val("rel_we", Write_enable, 0);

    // Directed: add, carry out, use-flag carry, report-only
    issue(ALU_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);  // 5+7 = 0xC
    check_val("add_count", Instr_Count, 1);
    issue(ALU_ADD, 4'd4, 4'd5, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);  // FFFF+1 carries
    check_val("ovf_carry", Carry_Flag, 1);
    issue(ALU_ADD, 4'd6, 4'd7, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);  // 0+0+flag = 1
    check_val("useflag_res", Result, 17'h00001);
    issue(ALU_ADD, 4'd1, 4'd1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0); // report only
    issue(ALU_OR, 4'd10, 4'd10, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0); // reads unchanged r10

`ifdef ALU_SEQ_HOST_LOAD_EN
    // Simultaneous load and instruction: load goes first
    Load_Valid = 1'b1; Load_Addr = 4'd12; Load_Data = 16'($urandom);
    Instr_Valid = 1'b1; Instr_Opcode = ALU_PASS_A; Instr_Rs1 = 4'd12;
    #1;
    check_val("load_iready", Instr_Ready, 0);
    check_val("load_we", Write_enable, 1);
    check_val("load_waddr", Write_Addr, 12);
    check_val("load_wdata", Write_data, Load_Data);
    @(posedge Clock); #1;
    m_rf[12] = Load_Data;
    Load_Valid = 1'b0;
    check_val("load_rf", dp_rf[12], m_rf[12]);
    check_val("load_count", Instr_Count, m_count);
    issue(ALU_PASS_A, 4'd12, 4'd0, 4'd13, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Reset during EXEC aborts the instruction
    Instr_Valid = 1'b1; Instr_Opcode = ALU_XOR; Instr_Rs1 = 4'd1; Instr_Rs2 = 4'd4;
    Instr_Rd = 4'd14; Instr_Carry = 1'b1; Instr_Use_Flag = 1'b0; Instr_Wb = 1'b1;
    @(posedge Clock); #1;
    Instr_Valid = 1'b0;
    Reset_n = 1'b0;
    #1;
    check_val("abort_ready", Instr_Ready, 0);
    check_val("abort_rvalid", Result_Valid, 0);
    check_val("abort_we", Write_enable, 0);
    check_val("abort_ra1", Read_Addr_1, 0);
    check_val("abort_ra2", Read_Addr_2, 0);
    check_val("abort_op", Opcode, 0);
    check_val("abort_cin", Carry_In, 0);
    check_val("abort_waddr", Write_Addr, 0);
    check_val("abort_wdata", Write_data, 0);
    check_val("abort_result", Result, 0);
    check_val("abort_carry", Carry_Flag, 0);
    check_val("abort_count", Instr_Count, 0);
    repeat (2) begin
      @(posedge Clock); #1;
      check_val("abort_hold_rv", Result_Valid, 0);
      check_val("abort_hold_we", Write_enable, 0);
    end
    check_val("abort_rf", dp_rf[14], m_rf[14]);
    m_carry = 1'b0; m_count = 0;
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock); #1;

    // Back-to-back chain, each Rs1 is the previous Rd
    issue(ALU_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(ALU_SUB, 4'd3, 4'd5, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(ALU_XOR, 4'd4, 4'd2, 4'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(ALU_ADD, 4'd6, 4'd6, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("b2b_count", Instr_Count, 4);

    // Random instructions, some back-to-back
    for (int i = 0; i < 40; i++) begin
      issue(aluop_t'($urandom_range(0, 5)), 4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            (i != 39) && ($urandom_range(0, 1) == 1));
    end
    Instr_Valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
